store_buffer: RTL and testbench

Storage-side endpoint of the LSU store-allocation interface. Store instructions are buffered here in program order from allocation until ROB commit, then drained one at a time to the D-cache write port. Uncommitted entries are discarded on pipeline flush. The block answers LSU byte-granular load-forward lookups and reports to the AGU whether any buffered store targets a non-idempotent region.

---
 rtl/store_buffer.sv | 155 +++++++++++++++
 tb/tb_store_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: holds stores in program order from allocation to ROB commit,
// drains committed stores to the D-cache and forwards bytes to younger loads.
module store_buffer #(
  parameter int DEPTH  = 8,
  parameter int XLEN   = 32,
  parameter int MASK_W = XLEN / 8,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [XLEN-1:0]   alloc_addr,
  input  logic [XLEN-1:0]   alloc_data,
  input  logic [MASK_W-1:0] alloc_mask,
  input  logic [TAG_W-1:0]  alloc_rob_tag,
  input  logic              alloc_nonidem,
  output logic              sb_full,
  output logic              sb_empty,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_rob_tag,
  input  logic [XLEN-1:0]   find_addr,
  input  logic [MASK_W-1:0] find_mask,
  output logic              fwd_hit,
  output logic [XLEN-1:0]   fwd_data,
  output logic [MASK_W-1:0] fwd_mask,
  output logic              nonidem_exists,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_data,
  output logic [MASK_W-1:0] mem_req_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d, cmt_ptr_q, cmt_ptr_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d, cmt_count_q, cmt_count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, cmt_q, cmt_d;

  logic [XLEN-1:0]   addr_q [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];
  logic [MASK_W-1:0] mask_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  nonidem_q;

  logic do_alloc, do_commit, do_pop;
  logic [XLEN-1:0]   fwd_data_c;
  logic [MASK_W-1:0] fwd_mask_c;

  // Only word-granular address bits take part in the forward match.
  logic unused_find_lsb;
  assign unused_find_lsb = ^find_addr[1:0];

  assign sb_full        = (count_q == CW'(DEPTH));
  assign sb_empty       = (count_q == '0);
  assign mem_req_valid  = (cmt_count_q != '0);
  assign mem_req_addr   = mem_req_valid ? addr_q[head_q] : '0;
  assign mem_req_data   = mem_req_valid ? data_q[head_q] : '0;
  assign mem_req_mask   = mem_req_valid ? mask_q[head_q] : '0;
  assign nonidem_exists = |(valid_q & nonidem_q);

  assign do_alloc  = alloc_valid & ~sb_full & ~flush;
  assign do_commit = commit_valid & (cmt_count_q < count_q) &
                     (commit_rob_tag == tag_q[cmt_ptr_q]);
  assign do_pop    = mem_req_valid & mem_req_ready;

  // Commit is resolved first so a same-cycle flush keeps the newly committed entry.
  always_comb begin
    valid_d     = valid_q;
    cmt_d       = cmt_q;
    head_d      = head_q;
    cmt_ptr_d   = cmt_ptr_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      cmt_d[head_q]   = 1'b0;
      head_d          = head_q + PW'(1);
    end
    if (do_commit) begin
      cmt_d[cmt_ptr_q] = 1'b1;
      cmt_ptr_d        = cmt_ptr_q + PW'(1);
    end
    cmt_count_d = cmt_count_q + CW'(do_commit) - CW'(do_pop);
    if (flush) begin
      tail_d  = cmt_ptr_d;
      count_d = cmt_count_d;
      valid_d = valid_d & cmt_d;
    end else begin
      if (do_alloc) begin
        valid_d[tail_q] = 1'b1;
        cmt_d[tail_q]   = 1'b0;
        tail_d          = tail_q + PW'(1);
      end
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      cmt_ptr_q   <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cmt_count_q <= '0;
      valid_q     <= '0;
      cmt_q       <= '0;
    end else begin
      head_q      <= head_d;
      cmt_ptr_q   <= cmt_ptr_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cmt_count_q <= cmt_count_d;
      valid_q     <= valid_d;
      cmt_q       <= cmt_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      addr_q[tail_q]    <= alloc_addr;
      data_q[tail_q]    <= alloc_data;
      mask_q[tail_q]    <= alloc_mask;
      tag_q[tail_q]     <= alloc_rob_tag;
      nonidem_q[tail_q] <= alloc_nonidem;
    end
  end

  // Walk oldest to youngest so younger matching stores overwrite older bytes.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_data_c = '0;
    fwd_mask_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx][XLEN-1:2] == find_addr[XLEN-1:2])) begin
        for (int b = 0; b < MASK_W; b++) begin
          if (mask_q[idx][b] && find_mask[b]) begin
            fwd_data_c[8*b +: 8] = data_q[idx][8*b +: 8];
            fwd_mask_c[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_data = fwd_data_c;
  assign fwd_mask = fwd_mask_c;
  assign fwd_hit  = |fwd_mask_c;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: allocation, forwarding, commit/drain,
// flush interactions, non-idempotent tracking, pointer wrap and async reset.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic [31:0] alloc_addr;
  logic [31:0] alloc_data;
  logic [3:0]  alloc_mask;
  logic [4:0]  alloc_rob_tag;
  logic        alloc_nonidem;
  logic        sb_full, sb_empty;
  logic        commit_valid;
  logic [4:0]  commit_rob_tag;
  logic [31:0] find_addr;
  logic [3:0]  find_mask;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic        nonidem_exists;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0]  mem_req_mask;

  int checks = 0;
  int failures = 0;

  store_buffer #(.DEPTH(8), .XLEN(32), .MASK_W(4), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_data(alloc_data),
    .alloc_mask(alloc_mask), .alloc_rob_tag(alloc_rob_tag), .alloc_nonidem(alloc_nonidem),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag),
    .find_addr(find_addr), .find_mask(find_mask),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_mask(fwd_mask),
    .nonidem_exists(nonidem_exists),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [4:0] t, input logic ni);
    alloc_valid = 1'b1; alloc_addr = a; alloc_data = d;
    alloc_mask = m; alloc_rob_tag = t; alloc_nonidem = ni;
    tick();
    alloc_valid = 1'b0; alloc_nonidem = 1'b0;
  endtask

  task automatic do_commit(input logic [4:0] t);
    commit_valid = 1'b1; commit_rob_tag = t;
    tick();
    commit_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_addr = '0; alloc_data = '0;
    alloc_mask = '0; alloc_rob_tag = '0; alloc_nonidem = 1'b0; commit_valid = 1'b0;
    commit_rob_tag = '0; find_addr = '0; find_mask = '0; mem_req_ready = 1'b0;
    #1;
    chk("rst_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_full", {31'b0, sb_full}, 32'd0);
    chk("rst_mvalid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_maddr", mem_req_addr, 32'h0);
    chk("rst_nonidem", {31'b0, nonidem_exists}, 32'd0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single store: invisible in its alloc cycle, forwarded after.
    find_addr = 32'h100; find_mask = 4'h3;
    alloc_valid = 1'b1; alloc_addr = 32'h100; alloc_data = 32'hAABBCCDD;
    alloc_mask = 4'hF; alloc_rob_tag = 5'd3;
    #1;
    chk("same_cycle_hit", {31'b0, fwd_hit}, 32'd0);
    tick();
    alloc_valid = 1'b0;
    chk("t1_empty", {31'b0, sb_empty}, 32'd0);
    chk("t1_mvalid_uncommitted", {31'b0, mem_req_valid}, 32'd0);
    chk("t1_hit", {31'b0, fwd_hit}, 32'd1);
    chk("t1_fmask", {28'b0, fwd_mask}, 32'h3);
    chk("t1_fdata", fwd_data, 32'h0000CCDD);
    do_commit(5'd3);
    chk("t1_mvalid", {31'b0, mem_req_valid}, 32'd1);
    chk("t1_maddr", mem_req_addr, 32'h100);
    chk("t1_mdata", mem_req_data, 32'hAABBCCDD);
    chk("t1_mmask", {28'b0, mem_req_mask}, 32'hF);
    mem_req_ready = 1'b1;
    #1;
    chk("t1_fwd_during_pop", {31'b0, fwd_hit}, 32'd1);
    tick();
    mem_req_ready = 1'b0;
    chk("t1_drained_empty", {31'b0, sb_empty}, 32'd1);
    chk("t1_drained_mvalid", {31'b0, mem_req_valid}, 32'd0);

    // Youngest store wins per byte.
    do_alloc(32'h200, 32'h11111111, 4'hF, 5'd1, 1'b0);
    do_alloc(32'h200, 32'h22220000, 4'hC, 5'd2, 1'b0);
    find_addr = 32'h200; find_mask = 4'hF;
    #1;
    chk("t2_fdata", fwd_data, 32'h22221111);
    chk("t2_fmask", {28'b0, fwd_mask}, 32'hF);
    find_addr = 32'h202; find_mask = 4'h6;
    #1;
    chk("t2_part_fdata", fwd_data, 32'h00221100);
    chk("t2_part_fmask", {28'b0, fwd_mask}, 32'h6);
    find_addr = 32'h204; find_mask = 4'hF;
    #1;
    chk("t2_other_word_hit", {31'b0, fwd_hit}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_empty", {31'b0, sb_empty}, 32'd1);

    // Fill, reject overflow, commit with ready low, then drain back to back.
    for (int i = 0; i < 8; i++) begin
      do_alloc(32'h1000 + 32'(4 * i), 32'hD0000000 + 32'(i), 4'hF, 5'(i), 1'b0);
      if (i == 6) chk("t3_full_at7", {31'b0, sb_full}, 32'd0);
    end
    chk("t3_full", {31'b0, sb_full}, 32'd1);
    do_alloc(32'h2000, 32'hDEADBEEF, 4'hF, 5'd8, 1'b0);
    find_addr = 32'h2000; find_mask = 4'hF;
    #1;
    chk("t3_overflow_ignored", {31'b0, fwd_hit}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_commit(5'(i));
      if (i == 0) chk("t3_mvalid_first", {31'b0, mem_req_valid}, 32'd1);
    end
    chk("t3_maddr_stable", mem_req_addr, 32'h1000);
    chk("t3_still_full", {31'b0, sb_full}, 32'd1);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_data", mem_req_data, 32'hD0000000 + 32'(i));
      tick();
    end
    mem_req_ready = 1'b0;
    chk("t3_empty", {31'b0, sb_empty}, 32'd1);
    chk("t3_mvalid_end", {31'b0, mem_req_valid}, 32'd0);

    // Flush keeps only committed stores.
    for (int i = 0; i < 4; i++)
      do_alloc(32'h300 + 32'(4 * i), 32'h30000000 + 32'(i), 4'hF, 5'(10 + i), 1'b0);
    do_commit(5'd10);
    do_commit(5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    find_addr = 32'h308; find_mask = 4'hF;
    #1;
    chk("t4_flushed_gone", {31'b0, fwd_hit}, 32'd0);
    find_addr = 32'h304;
    #1;
    chk("t4_committed_kept", fwd_data, 32'h30000001);
    mem_req_ready = 1'b1;
    chk("t4_drain0", mem_req_data, 32'h30000000);
    tick();
    chk("t4_drain1", mem_req_data, 32'h30000001);
    tick();
    mem_req_ready = 1'b0;
    chk("t4_empty", {31'b0, sb_empty}, 32'd1);
    alloc_valid = 1'b1; alloc_addr = 32'h340; alloc_data = 32'h1; alloc_rob_tag = 5'd14;
    flush = 1'b1;
    tick();
    alloc_valid = 1'b0; flush = 1'b0;
    chk("t4_flush_drops_alloc", {31'b0, sb_empty}, 32'd1);
    do_alloc(32'h350, 32'h35353535, 4'hF, 5'd15, 1'b0);
    commit_valid = 1'b1; commit_rob_tag = 5'd15; flush = 1'b1;
    tick();
    commit_valid = 1'b0; flush = 1'b0;
    chk("t4_commit_before_flush", {31'b0, mem_req_valid}, 32'd1);
    chk("t4_cbf_addr", mem_req_addr, 32'h350);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;

    // Non-idempotent tracking and wrong-tag commit.
    chk("t5_nonidem_before", {31'b0, nonidem_exists}, 32'd0);
    do_alloc(32'h600, 32'h66666666, 4'hF, 5'd5, 1'b1);
    chk("t5_nonidem_set", {31'b0, nonidem_exists}, 32'd1);
    do_commit(5'd6);
    chk("t5_wrong_tag", {31'b0, mem_req_valid}, 32'd0);
    do_commit(5'd5);
    chk("t5_right_tag", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("t5_nonidem_cleared", {31'b0, nonidem_exists}, 32'd0);

    // Streaming alloc/commit/drain across pointer wrap.
    mem_req_ready = 1'b1;
    for (int t = 0; t < 22; t++) begin
      alloc_valid = (t < 20);
      alloc_addr = 32'h4000 + 32'(4 * t);
      alloc_data = 32'hC0DE0000 + 32'(t);
      alloc_mask = 4'hF; alloc_rob_tag = 5'(t);
      commit_valid = (t >= 1) && (t <= 20);
      commit_rob_tag = 5'(t - 1);
      #1;
      if (t >= 2) chk("t6_wrap_data", mem_req_data, 32'hC0DE0000 + 32'(t - 2));
      tick();
    end
    alloc_valid = 1'b0; commit_valid = 1'b0; mem_req_ready = 1'b0;
    chk("t6_empty", {31'b0, sb_empty}, 32'd1);

    // Asynchronous reset mid-drain.
    do_alloc(32'h500, 32'h55555555, 4'hF, 5'd7, 1'b0);
    do_commit(5'd7);
    chk("t7_mvalid_before", {31'b0, mem_req_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_mvalid", {31'b0, mem_req_valid}, 32'd0);
    chk("t7_rst_maddr", mem_req_addr, 32'h0);
    chk("t7_rst_empty", {31'b0, sb_empty}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
